// File: rtl/dp_sequencer_pkg.sv
// dp_sequencer_pkg
//   Shared encodings for the datapath sequencer: command kinds, ALU opcodes,
//   FSM state encoding and the legality check applied to a new command.
package dp_sequencer_pkg;

  localparam logic [1:0] CMD_LOAD    = 2'b00;
  localparam logic [1:0] CMD_BINOP   = 2'b01;
  localparam logic [1:0] CMD_SUB     = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  localparam logic [2:0] OPC_AND  = 3'b000;
  localparam logic [2:0] OPC_OR   = 3'b001;
  localparam logic [2:0] OPC_NOTA = 3'b010;
  localparam logic [2:0] OPC_NOTB = 3'b011;
  localparam logic [2:0] OPC_ADD  = 3'b100;
  localparam logic [2:0] OPC_NEGA = 3'b101;
  localparam logic [2:0] OPC_NEGB = 3'b110;
  localparam logic [2:0] OPC_BAD  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4,
    ST_NEG_B   = 3'd5,
    ST_NEGWB_B = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  // A command is rejected if its kind is unassigned, or if it is a BINOP
  // carrying the one opcode the ALU does not implement.
  function automatic logic cmd_is_illegal(logic [1:0] kind, logic [2:0] opc);
    return (kind == CMD_ILLEGAL) || ((kind == CMD_BINOP) && (opc == OPC_BAD));
  endfunction

endpackage

// File: rtl/dp_ack_timer.sv
// dp_ack_timer
//   Counts consecutive cycles spent waiting for mem_ack.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count (takes priority over tick)
//   tick       : one more cycle without ack
//   last       : count has reached TO_CYCLES-1, so one more ack-less cycle
//                completes the timeout
module dp_ack_timer #(
  parameter int CNT_W     = 4,
  parameter int TO_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic last
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == TO_LAST);

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer
//   Drives the read/write enables and ALU opcode of the two-operand
//   register/ALU datapath for one command at a time.
//   start/cmd_kind/cmd_opc/cmd_dst : command, sampled only when idle
//   mem_req/mem_ack                : operand fetch handshake; mem_req is held
//                                    for the whole fetch state, the operand on
//                                    mdr is written in the cycle mem_ack=1
//   *ren/*wen, opc                 : datapath controls
//   busy, done, err                : status (done/err are one-cycle pulses)
//   dbg_state                      : current FSM state
module dp_sequencer
  import dp_sequencer_pkg::*;
#(
  parameter int TO_CYCLES = 15,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd_kind,
  input  logic [2:0] cmd_opc,
  input  logic       cmd_dst,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic       aren,
  output logic       bren,
  output logic       tren,
  output logic       r1ren,
  output logic       r2ren,
  output logic       awen,
  output logic       bwen,
  output logic       twen,
  output logic       r1wen,
  output logic       r2wen,
  output logic [2:0] opc,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  state_e     state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic [2:0] opc_q, opc_d;
  logic       dst_q, dst_d;
  logic       hold_q, hold_d;   // keeps the dst read enable up while idle
  logic       err_q, err_d;
  logic       dst_wen, dst_ren;
  logic       tm_clr, tm_tick, tm_last;

  dp_ack_timer #(.CNT_W(CNT_W), .TO_CYCLES(TO_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tm_clr),
    .tick (tm_tick),
    .last (tm_last)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    opc_d   = opc_q;
    dst_d   = dst_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    mem_req = 1'b0;
    aren    = 1'b0;
    bren    = 1'b0;
    tren    = 1'b0;
    awen    = 1'b0;
    bwen    = 1'b0;
    twen    = 1'b0;
    dst_wen = 1'b0;
    opc     = OPC_AND;
    done    = 1'b0;
    tm_tick = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d = 1'b0;
          if (cmd_is_illegal(cmd_kind, cmd_opc)) begin
            err_d = 1'b1;
          end else begin
            kind_d  = cmd_kind;
            opc_d   = cmd_opc;
            dst_d   = cmd_dst;
            state_d = ST_FETCH_A;
          end
        end
      end
      ST_FETCH_A: begin
        mem_req = 1'b1;
        tm_tick = !mem_ack;
        if (mem_ack) begin
          // LOAD routes the mdr word straight into the destination.
          if (kind_q == CMD_LOAD) begin
            dst_wen = 1'b1;
            state_d = ST_DONE;
          end else begin
            awen    = 1'b1;
            state_d = ST_FETCH_B;
          end
        end else if (tm_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FETCH_B: begin
        mem_req = 1'b1;
        tm_tick = !mem_ack;
        if (mem_ack) begin
          bwen    = 1'b1;
          state_d = (kind_q == CMD_SUB) ? ST_NEG_B : ST_EXEC;
        end else if (tm_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_NEG_B: begin
        bren    = 1'b1;
        opc     = OPC_NEGB;
        twen    = 1'b1;
        state_d = ST_NEGWB_B;
      end
      ST_NEGWB_B: begin
        tren    = 1'b1;
        bwen    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        aren    = 1'b1;
        bren    = 1'b1;
        twen    = 1'b1;
        opc     = (kind_q == CMD_SUB) ? OPC_ADD : opc_q;
        state_d = ST_WB;
      end
      ST_WB: begin
        tren    = 1'b1;
        dst_wen = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        hold_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Any state change restarts the ack-wait count.
    tm_clr  = (state_d != state_q);
    dst_ren = (state_q == ST_DONE) || hold_q;
  end

  assign r1wen     = dst_wen && !dst_q;
  assign r2wen     = dst_wen &&  dst_q;
  assign r1ren     = dst_ren && !dst_q;
  assign r2ren     = dst_ren &&  dst_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= CMD_LOAD;
      opc_q   <= OPC_AND;
      dst_q   <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      opc_q   <= opc_d;
      dst_q   <= dst_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer
//   Drives commands into dp_sequencer with a behavioural register/ALU datapath
//   and memory responder attached, and compares final register contents,
//   latency and status pulses against an arithmetic reference.
module tb_dp_sequencer;
  import dp_sequencer_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd_kind = 2'b00;
  logic [2:0] cmd_opc = 3'b000;
  logic       cmd_dst = 1'b0;
  logic       mem_req, mem_ack = 1'b0;
  logic       aren, bren, tren, r1ren, r2ren;
  logic       awen, bwen, twen, r1wen, r2wen;
  logic [2:0] opc;
  logic       busy, done, err;
  logic [2:0] dbg_state;

  dp_sequencer #(.TO_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_kind(cmd_kind),
    .cmd_opc(cmd_opc), .cmd_dst(cmd_dst), .mem_req(mem_req), .mem_ack(mem_ack),
    .aren(aren), .bren(bren), .tren(tren), .r1ren(r1ren), .r2ren(r2ren),
    .awen(awen), .bwen(bwen), .twen(twen), .r1wen(r1wen), .r2wen(r2wen),
    .opc(opc), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- datapath + memory model ----------------
  logic [31:0] mdr = 32'h0;
  logic [31:0] a_r = 32'h0, b_r = 32'h0, t_r = 32'h0, r1_r = 32'h0, r2_r = 32'h0;
  logic [31:0] bus;
  logic [16:0] outs;

  assign bus  = tren ? t_r : mdr;
  assign outs = {mem_req, aren, bren, tren, r1ren, r2ren, awen, bwen, twen,
                 r1wen, r2wen, opc, busy, done, err};

  function automatic logic [31:0] alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~a;
      3'b011:  return ~b;
      3'b100:  return a + b;
      3'b101:  return -a;
      3'b110:  return -b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (awen)  a_r  <= bus;
    if (bwen)  b_r  <= bus;
    if (twen)  t_r  <= alu(opc, a_r, b_r);
    if (r1wen) r1_r <= bus;
    if (r2wen) r2_r <= bus;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(logic [1:0] kind, logic [2:0] op,
                                             logic [31:0] a, logic [31:0] b);
    if (kind == 2'b00) return a;
    if (kind == 2'b10) return a - b;
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~b;
      3'd4:    return a + b;
      3'd5:    return 32'd0 - a;
      default: return 32'd0 - b;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [1:0] kind, input logic [2:0] op, input logic dst,
                         input logic [31:0] a, input logic [31:0] b,
                         input int wa, input int wb, input bit noise);
    bit illegal, exp_err;
    int lat_exp, err_at, done_at, err_seen_at, acks, nowait;
    int viol_bus, viol_two, viol_wen, en_seen, busy_seen;
    logic [31:0] dst_before, other_before, exp_val, dst_now, other_now;

    illegal = (kind == 2'b11) || (kind == 2'b01 && op == 3'b111);
    exp_err = 1'b1;
    lat_exp = 0;
    if (illegal)                      err_at = 1;
    else if (wa >= TO)                err_at = 1 + TO;
    else if (kind != 2'b00 && wb >= TO) err_at = 2 + wa + TO;
    else begin
      exp_err = 1'b0;
      err_at  = -1;
      lat_exp = (kind == 2'b00) ? 2 + wa : (kind == 2'b01) ? 5 + wa + wb : 7 + wa + wb;
      exp_q.push_back(ref_result(kind, op, a, b));
    end
    dst_before   = dst ? r2_r : r1_r;
    other_before = dst ? r1_r : r2_r;

    @(negedge clk);
    start = 1'b1; cmd_kind = kind; cmd_opc = op; cmd_dst = dst; mem_ack = 1'b0;
    done_at = -1; err_seen_at = -1; acks = 0; nowait = 0;
    viol_bus = 0; viol_two = 0; viol_wen = 0; en_seen = 0; busy_seen = 0;

    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise && busy && !done) begin
        start    = 1'($urandom_range(0, 1));
        cmd_kind = 2'($urandom_range(0, 3));
        cmd_opc  = 3'($urandom_range(0, 7));
        cmd_dst  = 1'($urandom_range(0, 1));
      end
      mem_ack = 1'b0;
      mdr     = $urandom;
      if (mem_req) begin
        if (nowait == ((acks == 0) ? wa : wb)) begin
          mem_ack = 1'b1;
          mdr     = (acks == 0) ? a : b;
          acks++;
          nowait  = 0;
        end else begin
          nowait++;
        end
      end
      #1;
      if (tren && mem_req) viol_bus++;
      if (r1wen && r2wen) viol_two++;
      if ((awen || bwen || r1wen || r2wen) && mem_req && !mem_ack) viol_wen++;
      if (|{aren, bren, tren, r1ren, r2ren, awen, bwen, twen, r1wen, r2wen}) en_seen++;
      if (busy) busy_seen++;
      if (done && done_at < 0) done_at = k;
      if (err && err_seen_at < 0) err_seen_at = k;
      if (done_at >= 0 || err_seen_at >= 0) break;
    end
    start   = 1'b0;
    mem_ack = 1'b0;

    if (done_at < 0 && err_seen_at < 0)
      check("cmd_finished_in_bound", 32'd0, 32'd1);

    dst_now   = dst ? r2_r : r1_r;
    other_now = dst ? r1_r : r2_r;
    check("bus_tren_vs_req", viol_bus, 0);
    check("single_reg_wen", viol_two, 0);
    check("wen_only_on_ack", viol_wen, 0);
    check("other_reg_kept", other_now, other_before);

    if (exp_err) begin
      check("err_cycle", err_seen_at, err_at);
      check("no_done_on_err", (done_at >= 0) ? 32'd1 : 32'd0, 32'd0);
      check("dst_kept_on_err", dst_now, dst_before);
      check("busy_at_err", busy, 1'b0);
      if (illegal) begin
        check("illegal_no_enables", en_seen, 0);
        check("illegal_not_busy", busy_seen, 0);
      end
    end else begin
      check("latency", done_at, lat_exp);
      check("no_err_pulse", (err_seen_at >= 0) ? 32'd1 : 32'd0, 32'd0);
      exp_val = exp_q.pop_front();
      check("dst_result", dst_now, exp_val);
      @(negedge clk);
      check("ren_hold_idle", {busy, r1ren, r2ren}, {1'b0, !dst, dst});
    end
  endtask

  task automatic reset_mid_exec();
    int pulses;
    @(negedge clk);
    start = 1'b1; cmd_kind = 2'b01; cmd_opc = 3'b100; cmd_dst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      start   = 1'b0;
      mem_ack = 1'b1;
      mdr     = $urandom;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("in_exec_before_reset", {aren, bren, twen}, 3'b111);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs, 17'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || err || busy) pulses++;
    end
    check("no_pulse_after_reset", pulses, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 17'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", outs, 17'd0);

    run_cmd(CMD_LOAD,  3'd0, 1'b0, 32'd30, 32'd0, 0, 0, 1'b0);
    run_cmd(CMD_BINOP, 3'd4, 1'b1, 32'd30, 32'd25, 0, 0, 1'b0);
    run_cmd(CMD_SUB,   3'd0, 1'b0, 32'd30, 32'd25, 0, 0, 1'b0);
    run_cmd(CMD_SUB,   3'd0, 1'b0, 32'd25, 32'd30, 0, 0, 1'b0);
    run_cmd(CMD_BINOP, 3'd0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 3, 1'b0);
    run_cmd(CMD_BINOP, 3'd1, 1'b0, 32'h1, 32'h2, 0, 100, 1'b0);
    run_cmd(CMD_LOAD,  3'd0, 1'b1, 32'h5, 32'h0, 100, 0, 1'b0);
    run_cmd(CMD_ILLEGAL, 3'd4, 1'b0, 32'h7, 32'h8, 0, 0, 1'b0);
    run_cmd(CMD_BINOP, 3'd7, 1'b1, 32'h7, 32'h8, 0, 0, 1'b0);
    run_cmd(CMD_SUB,   3'd0, 1'b1, 32'h8000_0000, 32'h1, 1, 2, 1'b1);
    run_cmd(CMD_BINOP, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, TO - 1, 1'b1);

    reset_mid_exec();
    run_cmd(CMD_LOAD,  3'd0, 1'b1, 32'h1234_5678, 32'h0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int wa, wb;
      wa = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      wb = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, wa, wb, 1'($urandom_range(0, 1)));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Control-side counterpart of the two-operand register/ALU datapath: accepts one command at a time and drives every datapath read/write enable and the ALU opcode, cycle by cycle.
- Fetches operands over a req/ack memory-data handshake (data arrives on the datapath's mdr bus) and steers the result into R1 or R2.
- Sits between the instruction/command source and the datapath; it replaces hand-driven enable sequences.

Parameters:
TO_CYCLES, 15, max cycles waiting for mem_ack before abort (1..2^CNT_W-1)
CNT_W, 4, width of the ack-timeout counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
cmd_kind  input  2  00 LOAD, 01 BINOP, 10 SUB (A-B), 11 illegal
cmd_opc  input  3  ALU opcode for BINOP
cmd_dst  input  1  0 = R1, 1 = R2
mem_req  output  1  request operand on mdr
mem_ack  input  1  mdr valid this cycle
aren, bren, tren, r1ren, r2ren  output  1 each  datapath read enables
awen, bwen, twen, r1wen, r2wen  output  1 each  datapath write enables
opc  output  3  ALU opcode
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse, command completed
err  output  1  one-cycle pulse, illegal command or ack timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE. All enables, mem_req, done, err and busy are 0. opc=000. Timeout counter is 0. A reset mid-command abandons the command and raises no pulse.
- On start in IDLE, latch cmd_kind, cmd_opc and cmd_dst. Inputs arriving while busy=1 are ignored.
- Illegal start (cmd_kind=11, or BINOP with cmd_opc=111): err=1 for 1 cycle, stay IDLE, no enables.
- States: IDLE, FETCH_A, FETCH_B, EXEC, WB, NEG_B, NEGWB_B, DONE.
- FETCH_A / FETCH_B:
  - mem_req=1 throughout the state.
  - The write enable is Mealy: asserted in the same cycle mem_ack=1.
  - FETCH_A enables awen, or the dst wen for LOAD. FETCH_B enables bwen.
  - Leave the state on ack.
  - Counter increments each cycle without ack and clears on state change. When it reaches TO_CYCLES: err pulse, go to IDLE, no write.
- Transitions:
  - LOAD: FETCH_A -> DONE. The mdr word is written directly to the dst register; tren=0 so the bus carries mdr.
  - BINOP: FETCH_A -> FETCH_B -> EXEC -> WB -> DONE.
  - SUB: FETCH_A -> FETCH_B -> NEG_B -> NEGWB_B -> EXEC -> WB -> DONE.
- Per-state outputs:
  - NEG_B: bren=1, opc=110, twen=1.
  - NEGWB_B: tren=1, bwen=1 (B <= -B).
  - EXEC: aren=1, bren=1, twen=1. opc=cmd_opc for BINOP, 100 for SUB.
  - WB: tren=1, dst wen=1.
  - DONE: done=1, dst ren=1. The dst ren (r1ren/r2ren) stays high in IDLE until the next accepted start.
- opc=000 in every state other than NEG_B and EXEC.
- Bus rule: tren is never high while mem_req=1. aren/bren are high only in EXEC and NEG_B. At most one of r1wen/r2wen is high in any cycle.
- Latency with zero-wait ack (start cycle to done, inclusive of DONE): LOAD 2, BINOP 5, SUB 7. Each ack wait adds 1 cycle.
- ALU width/overflow is the datapath's concern: 32-bit two's complement wrap. The sequencer does not inspect data.

Decomposition:
- Shared package holds:
  - cmd_kind encodings: CMD_LOAD, CMD_BINOP, CMD_SUB.
  - ALU opcode constants: OPC_AND=000, OPC_OR=001, OPC_NOTA=010, OPC_NOTB=011, OPC_ADD=100, OPC_NEGA=101, OPC_NEGB=110.
  - State encoding.
- One natural sub-module, dp_ack_timer: the CNT_W counter with clear and expiry flag. Everything else lives in one FSM module.
- Integration bench instantiates dp_sequencer, datapath_1 and a memory model driving mdr on ack.

Test Plan:
- LOAD, dst=R1, mdr=30, ack on first req cycle -> r1wen high 1 cycle, R1=30, done at cycle 2, r1ren high afterwards.
- BINOP opc=100, mdr=30 then 25, immediate acks -> T=55 after EXEC, R2 (dst=1) =55, done at cycle 5, no tren overlap with mem_req.
- SUB, mdr=30 then 25 -> NEG_B writes T=-25, B=-25, R1=5, done at cycle 7. Repeat with 25/30 -> R1=32'hFFFFFFFB.
- FETCH_B ack withheld 3 cycles -> mem_req held, bwen only in the ack cycle, done delayed by 3. Ack never arrives with TO_CYCLES=15 -> err pulse 15 cycles into FETCH_B, no bwen, IDLE.
- cmd_kind=11, and BINOP with cmd_opc=111 -> err pulse, busy stays 0, all enables 0. start pulsed while busy -> ignored, current command completes unchanged.
- rst_n low during EXEC -> all outputs 0 immediately (async), no done/err. The next start after release behaves as after a fresh reset.
